surf_id_ctrl: RTL and testbench



---
 rtl/surf_id_ctrl_pkg.sv | 18 +
 rtl/surf_id_ctrl_if.sv | 15 +
 rtl/surf_id_ctrl_sat_event_counter.sv | 44 ++++
 rtl/surf_id_ctrl.sv | 116 +++++++++++
 tb/tb_surf_id_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/surf_id_ctrl_pkg.sv
// Shared constants for the SURF identification/control register bank:
// word offsets on wb_adr_i[4:2], STATUS field positions, and the event count width.
package surf_id_ctrl_pkg;

  localparam logic [2:0] ADDR_IDENT       = 3'd0;
  localparam logic [2:0] ADDR_DATEVERSION = 3'd1;
  localparam logic [2:0] ADDR_CONTROL     = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH     = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_LO   = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI   = 3'd5;
  localparam logic [2:0] ADDR_STATUS      = 3'd6;
  localparam logic [2:0] ADDR_PULSE       = 3'd7;

  localparam int STATUS_FLAG_BIT = 0;
  localparam int STATUS_CNT_LSB  = 8;
  localparam int CNT_W           = 8;

endpackage

// File: rtl/surf_id_ctrl_if.sv
// WISHBONE slave bus as seen by the board-manager master: strobe/address/data
// from the master, registered ack and read data back.
interface surf_id_ctrl_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [21:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/surf_id_ctrl_sat_event_counter.sv
// Sticky event flag plus saturating event count; a coincident event beats a clear.
module sat_event_counter
  import surf_id_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             event_i,
  input  logic             clr_i,
  output logic             flag_o,
  output logic [CNT_W-1:0] count_o
);

  logic             flag_q, flag_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    flag_d  = flag_q;
    count_d = count_q;
    if (event_i) begin
      flag_d = 1'b1;
      if (clr_i)
        count_d = CNT_W'(1);
      else if (count_q != {CNT_W{1'b1}})
        count_d = count_q + CNT_W'(1);
    end else if (clr_i) begin
      flag_d  = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      flag_q  <= 1'b0;
      count_q <= '0;
    end else begin
      flag_q  <= flag_d;
      count_q <= count_d;
    end
  end

  assign flag_o  = flag_q;
  assign count_o = count_q;

endmodule

// File: rtl/surf_id_ctrl.sv
// SURF ID/control register bank: ident/version words, control, scratch,
// coherent 64-bit uptime, sticky event status and write-triggered pulses.
module surf_id_ctrl
  import surf_id_ctrl_pkg::*;
#(
  parameter logic [31:0] IDENT       = "SURF",
  parameter logic [31:0] DATEVERSION = 32'h0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  surf_id_ctrl_if.slave      wb,
  input  logic               event_i,
  output logic [7:0]         ctrl_o,
  output logic [7:0]         pulse_o
);

  logic        ack_q;
  logic [31:0] dat_q, dat_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  pulse_q, pulse_d;
  logic [63:0] uptime_q;
  logic [31:0] hi_shadow_q, hi_shadow_d;

  logic             access;
  logic             wr;
  logic [2:0]       widx;
  logic             status_clr;
  logic             ev_flag;
  logic [CNT_W-1:0] ev_count;
  logic [31:0]      rdata;
  logic             unused_adr;

  assign access     = wb.cyc & wb.stb & ~ack_q;
  assign wr         = access & wb.we;
  assign widx       = wb.adr[4:2];
  assign unused_adr = ^{wb.adr[21:5], wb.adr[1:0]};
  assign status_clr = wr & (widx == ADDR_STATUS) & wb.sel[0] & wb.dat_w[STATUS_FLAG_BIT];

  sat_event_counter u_evcnt (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .event_i (event_i),
    .clr_i   (status_clr),
    .flag_o  (ev_flag),
    .count_o (ev_count)
  );

  always_comb begin
    rdata = '0;
    unique case (widx)
      ADDR_IDENT:       rdata = IDENT;
      ADDR_DATEVERSION: rdata = DATEVERSION;
      ADDR_CONTROL:     rdata = {24'h0, ctrl_q};
      ADDR_SCRATCH:     rdata = scratch_q;
      ADDR_UPTIME_LO:   rdata = uptime_q[31:0];
      ADDR_UPTIME_HI:   rdata = hi_shadow_q;
      ADDR_STATUS: begin
        rdata[STATUS_FLAG_BIT]                     = ev_flag;
        rdata[STATUS_CNT_LSB +: CNT_W]             = ev_count;
      end
      default:          rdata = '0;
    endcase
  end

  always_comb begin
    dat_d       = dat_q;
    ctrl_d      = ctrl_q;
    scratch_d   = scratch_q;
    pulse_d     = '0;
    hi_shadow_d = hi_shadow_q;
    if (access) begin
      if (wb.we) begin
        dat_d = '0;
        if (widx == ADDR_CONTROL && wb.sel[0])
          ctrl_d = wb.dat_w[7:0];
        if (widx == ADDR_SCRATCH)
          for (int b = 0; b < 4; b++)
            if (wb.sel[b]) scratch_d[8*b +: 8] = wb.dat_w[8*b +: 8];
        if (widx == ADDR_PULSE && wb.sel[0])
          pulse_d = wb.dat_w[7:0];
      end else begin
        dat_d = rdata;
        // Latch the upper word alongside the lower so a later HI read is coherent
        if (widx == ADDR_UPTIME_LO)
          hi_shadow_d = uptime_q[63:32];
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q       <= 1'b0;
      dat_q       <= '0;
      ctrl_q      <= '0;
      scratch_q   <= '0;
      pulse_q     <= '0;
      uptime_q    <= '0;
      hi_shadow_q <= '0;
    end else begin
      ack_q       <= access;
      dat_q       <= dat_d;
      ctrl_q      <= ctrl_d;
      scratch_q   <= scratch_d;
      pulse_q     <= pulse_d;
      uptime_q    <= uptime_q + 64'd1;
      hi_shadow_q <= hi_shadow_d;
    end
  end

  assign wb.ack   = ack_q;
  assign wb.dat_r = dat_q;
  assign ctrl_o   = ctrl_q;
  assign pulse_o  = pulse_q;

endmodule

// File: tb/tb_surf_id_ctrl.sv
// Directed self-checking bench for surf_id_ctrl.
module tb_surf_id_ctrl;

  localparam logic [31:0] DV = 32'h1203_2417;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ev  = 1'b0;
  logic [7:0] ctrl;
  logic [7:0] pulse;

  int n_checks = 0;
  int n_fail   = 0;

  surf_id_ctrl_if bus ();

  surf_id_ctrl #(.IDENT("SURF"), .DATEVERSION(DV)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .event_i  (ev),
    .ctrl_o   (ctrl),
    .pulse_o  (pulse)
  );

  always #8 clk = ~clk;

  task automatic bus_idle();
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.sel = 4'h0; bus.adr = '0;   bus.dat_w = '0;
  endtask

  // Single access; lat = edges from strobe to ack (0 if no ack within budget)
  task automatic wb_access(input logic we, input logic [21:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, output logic [31:0] rdat, output int lat);
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = we;
    bus.adr = adr;  bus.sel = sel;  bus.dat_w = dat;
    lat = 0; rdat = 'x;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (bus.ack) begin lat = i; rdat = bus.dat_r; break; end
    end
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] r; int lat;
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.ack !== 1'b0 || bus.dat_r !== 32'h0) begin n_fail++;
      $display("FAIL reset_bus: ack=%b dat=%h required ack=0 dat=0", bus.ack, bus.dat_r); end
    n_checks++; if (ctrl !== 8'h0 || pulse !== 8'h0) begin n_fail++;
      $display("FAIL reset_outs: ctrl=%h pulse=%h required 00/00", ctrl, pulse); end
    @(negedge clk); rst = 1'b0;
    wb_access(1'b0, 22'h00, 4'hF, 0, r, lat);
    n_checks++; if (lat !== 1) begin n_fail++;
      $display("FAIL ident_latency: got %0d required 1", lat); end
    n_checks++; if (r !== 32'h5355_5246) begin n_fail++;
      $display("FAIL ident: got %h required 53555246", r); end
    wb_access(1'b0, 22'h04, 4'hF, 0, r, lat);
    n_checks++; if (r !== DV || lat !== 1) begin n_fail++;
      $display("FAIL dateversion: got %h lat %0d required %h lat 1", r, lat, DV); end
    wb_access(1'b0, 22'h14, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++;
      $display("FAIL hi_shadow_reset: got %h required 0", r); end
  endtask

  task automatic test_byte_enables();
    logic [31:0] r; int lat;
    wb_access(1'b1, 22'h0C, 4'hF, 32'h0, r, lat);
    wb_access(1'b1, 22'h0C, 4'b0101, 32'hA5A5_A5A5, r, lat);
    n_checks++; if (r !== 32'h0 || lat !== 1) begin n_fail++;
      $display("FAIL write_dat_zero: got %h lat %0d required 0 lat 1", r, lat); end
    wb_access(1'b0, 22'h0C, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h00A5_00A5) begin n_fail++;
      $display("FAIL scratch_sel: got %h required 00a500a5", r); end
    wb_access(1'b1, 22'h08, 4'hF, 32'h1FF, r, lat);
    n_checks++; if (ctrl !== 8'hFF) begin n_fail++;
      $display("FAIL ctrl_o: got %h required ff", ctrl); end
    wb_access(1'b1, 22'h08, 4'b1110, 32'h12, r, lat);
    wb_access(1'b0, 22'h08, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0000_00FF || ctrl !== 8'hFF) begin n_fail++;
      $display("FAIL ctrl_read: got %h ctrl %h required 000000ff ctrl ff", r, ctrl); end
    wb_access(1'b1, 22'h00, 4'hF, 32'hDEAD_BEEF, r, lat);
    wb_access(1'b0, 22'h00, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h5355_5246 || lat !== 1) begin n_fail++;
      $display("FAIL ro_write_ignored: got %h lat %0d required 53555246 lat 1", r, lat); end
  endtask

  task automatic test_uptime();
    logic [31:0] r; int lat;
    @(posedge clk); #1 force dut.uptime_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.uptime_q;
    wb_access(1'b0, 22'h10, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'hFFFF_FFFE) begin n_fail++;
      $display("FAIL uptime_lo_pre: got %h required fffffffe", r); end
    repeat (10) @(posedge clk);
    wb_access(1'b0, 22'h14, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++;
      $display("FAIL uptime_hi_coherent: got %h required 0", r); end
    @(posedge clk); #1 force dut.uptime_q = 64'h0000_0000_FFFF_FFFE;
    #1 release dut.uptime_q;
    repeat (2) @(posedge clk);
    wb_access(1'b0, 22'h10, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++;
      $display("FAIL uptime_lo_wrap: got %h required 0", r); end
    wb_access(1'b0, 22'h14, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h1) begin n_fail++;
      $display("FAIL uptime_hi_wrap: got %h required 1", r); end
  endtask

  task automatic test_event();
    logic [31:0] r; int lat;
    @(negedge clk); ev = 1'b1;
    repeat (300) @(negedge clk);
    ev = 1'b0;
    wb_access(1'b0, 22'h18, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0000_FF01) begin n_fail++;
      $display("FAIL status_saturate: got %h required 0000ff01", r); end
    wb_access(1'b1, 22'h18, 4'hF, 32'h1, r, lat);
    wb_access(1'b0, 22'h18, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++;
      $display("FAIL status_clear: got %h required 0", r); end
    @(negedge clk); ev = 1'b1; wb_access(1'b1, 22'h18, 4'hF, 32'h0, r, lat); ev = 1'b0;
    n_checks++; if (r !== 32'h0) begin n_fail++;
      $display("FAIL status_write0_dat: got %h required 0", r); end
    // Clear coincident with an event: event wins
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = 22'h18; bus.sel = 4'hF; bus.dat_w = 32'h1; ev = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.ack !== 1'b1) begin n_fail++;
      $display("FAIL clr_evt_ack: got %b required 1", bus.ack); end
    @(negedge clk); bus_idle(); ev = 1'b0;
    wb_access(1'b0, 22'h18, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0000_0101) begin n_fail++;
      $display("FAIL status_clr_evt: got %h required 00000101", r); end
  endtask

  task automatic test_pulse();
    logic [31:0] r; int lat;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = 22'h1C; bus.sel = 4'hF; bus.dat_w = 32'h81;
    n_checks++; if (pulse !== 8'h00) begin n_fail++;
      $display("FAIL pulse_early: got %h required 00", pulse); end
    @(posedge clk); #1;
    n_checks++; if (pulse !== 8'h81 || bus.ack !== 1'b1) begin n_fail++;
      $display("FAIL pulse_with_ack: pulse %h ack %b required 81/1", pulse, bus.ack); end
    @(negedge clk); bus_idle();
    @(posedge clk); #1;
    n_checks++; if (pulse !== 8'h00 || bus.ack !== 1'b0) begin n_fail++;
      $display("FAIL pulse_one_cycle: pulse %h ack %b required 00/0", pulse, bus.ack); end
    wb_access(1'b0, 22'h1C, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0 || lat !== 1) begin n_fail++;
      $display("FAIL pulse_read: got %h lat %0d required 0 lat 1", r, lat); end
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = 22'h1C; bus.sel = 4'b1110; bus.dat_w = 32'hFF;
    @(posedge clk); #1;
    n_checks++; if (pulse !== 8'h00) begin n_fail++;
      $display("FAIL pulse_nosel: got %h required 00", pulse); end
    @(negedge clk); bus_idle();
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = 22'h00; bus.sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      seen[i] = bus.ack;
    end
    @(negedge clk); bus_idle();
    n_checks++; if (seen !== 6'b010101) begin n_fail++;
      $display("FAIL back_to_back: acks %b required 010101 (cycle1 = lsb)", seen); end
  endtask

  task automatic test_reset_collision();
    logic [31:0] r; int lat;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b1;
    bus.adr = 22'h08; bus.sel = 4'hF; bus.dat_w = 32'h55; rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.ack !== 1'b0 || ctrl !== 8'h00) begin n_fail++;
      $display("FAIL rst_collision: ack %b ctrl %h required 0/00", bus.ack, ctrl); end
    @(negedge clk); bus_idle(); rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.ack !== 1'b0 || ctrl !== 8'h00) begin n_fail++;
      $display("FAIL rst_collision_after: ack %b ctrl %h required 0/00", bus.ack, ctrl); end
    wb_access(1'b0, 22'h0C, 4'hF, 0, r, lat);
    n_checks++; if (r !== 32'h0) begin n_fail++;
      $display("FAIL scratch_after_reset: got %h required 0", r); end
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_byte_enables();
    test_uptime();
    test_event();
    test_pulse();
    test_back_to_back();
    test_reset_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
